// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC generator, 1-cycle synchronous instruction ROM and an
// N-entry prefetch queue that feeds ID over a valid/ready handshake.
// Ports: clk, rst_n (async, active-low); uart_mode/uart_wen/uart_addr/
// uart_data load the ROM; pc_reset/redir_overload/redir_offset (+ values)
// redirect fetch; id_ready pops the head; inst_valid/inst/inst_pc show the
// head; queue_count gives occupancy; fetch_pc is the next PC to be issued.
module if_fetch_queue #(
    parameter int                   ISA_WIDTH   = 32,
    parameter int                   ROM_DEPTH   = 14,
    parameter int                   QUEUE_DEPTH = 4,
    parameter logic [ISA_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_mode,
    input  logic                          uart_wen,
    input  logic [ROM_DEPTH:0]            uart_addr,
    input  logic [ISA_WIDTH-1:0]          uart_data,
    input  logic                          redir_offset,
    input  logic [ISA_WIDTH-1:0]          redir_base,
    input  logic [ISA_WIDTH-1:0]          redir_offset_value,
    input  logic                          redir_overload,
    input  logic [ISA_WIDTH-1:0]          redir_overload_value,
    input  logic                          pc_reset,
    input  logic                          id_ready,
    output logic                          inst_valid,
    output logic [ISA_WIDTH-1:0]          inst,
    output logic [ISA_WIDTH-1:0]          inst_pc,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
    output logic [ISA_WIDTH-1:0]          fetch_pc
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {RUN, LOAD} state_e;

    state_e                 state_q, state_d;
    logic [ISA_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic                   inflight_q, inflight_d;
    logic [ISA_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
    logic [ISA_WIDTH-1:0]   mem_inst_q [QUEUE_DEPTH];
    logic [ISA_WIDTH-1:0]   mem_inst_d [QUEUE_DEPTH];
    logic [ISA_WIDTH-1:0]   mem_pc_q   [QUEUE_DEPTH];
    logic [ISA_WIDTH-1:0]   mem_pc_d   [QUEUE_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [ISA_WIDTH-1:0]   last_inst_q, last_inst_d;
    logic [ISA_WIDTH-1:0]   last_pc_q, last_pc_d;

    logic [ISA_WIDTH-1:0]   rom_mem [2**ROM_DEPTH];
    logic [ISA_WIDTH-1:0]   rom_rdata_q;
    logic [ROM_DEPTH-1:0]   rom_idx;
    logic                   rom_we;

    logic                   issue;
    logic                   flush;
    logic                   push;
    logic                   pop;
    logic                   redir;
    logic                   room;
    logic [CW:0]            occ;
    logic [ISA_WIDTH-1:0]   target;

    assign rom_idx = fetch_pc_q[ROM_DEPTH+1:2];
    assign rom_we  = (state_q == LOAD || uart_mode) && uart_wen
                     && !uart_addr[ROM_DEPTH];

    // ROM is deliberately not reset so a program survives rst_n.
    always_ff @(posedge clk) begin
        if (rom_we) begin
            rom_mem[uart_addr[ROM_DEPTH-1:0]] <= uart_data;
        end
        if (issue) begin
            rom_rdata_q <= rom_mem[rom_idx];
        end
    end

    assign inst_valid  = (count_q != '0);
    assign inst        = inst_valid ? mem_inst_q[rd_ptr_q] : last_inst_q;
    assign inst_pc     = inst_valid ? mem_pc_q[rd_ptr_q] : last_pc_q;
    assign queue_count = count_q;
    assign fetch_pc    = fetch_pc_q;

    assign pop   = inst_valid && id_ready;
    assign redir = pc_reset || redir_overload || redir_offset;
    // The in-flight read reserves a slot so its return always fits.
    assign occ   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign room  = occ < (CW+1)'(QUEUE_DEPTH);

    always_comb begin
        target = redir_base + (redir_offset_value << 2);
        if (pc_reset) begin
            target = RESET_PC;
        end else if (redir_overload) begin
            target = redir_overload_value;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        issue      = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            RUN: begin
                if (uart_mode) begin
                    state_d = LOAD;
                    flush   = 1'b1;
                    if (pc_reset) begin
                        fetch_pc_d = RESET_PC;
                    end
                end else if (redir) begin
                    flush      = 1'b1;
                    fetch_pc_d = target;
                end else if (room) begin
                    issue      = 1'b1;
                    fetch_pc_d = fetch_pc_q + ISA_WIDTH'(4);
                end
            end
            LOAD: begin
                flush = 1'b1;
                if (!uart_mode) begin
                    state_d    = RUN;
                    fetch_pc_d = RESET_PC;
                end else if (pc_reset) begin
                    fetch_pc_d = RESET_PC;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // A flush drops the read still in flight by simply never pushing it.
    assign push = inflight_q && !flush;

    always_comb begin
        mem_inst_d    = mem_inst_q;
        mem_pc_d      = mem_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
        last_inst_d   = inst;
        last_pc_d     = inst_pc;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_inst_d[wr_ptr_q] = rom_rdata_q;
                mem_pc_d[wr_ptr_q]   = inflight_pc_q;
                wr_ptr_d             = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            last_inst_q   <= '0;
            last_pc_q     <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                mem_inst_q[i] <= '0;
                mem_pc_q[i]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            last_inst_q   <= last_inst_d;
            last_pc_q     <= last_pc_d;
            mem_inst_q    <= mem_inst_d;
            mem_pc_q      <= mem_pc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: random and directed stimulus for if_fetch_queue,
// checked every cycle against a queue-based reference model.
module tb_if_fetch_queue;

    localparam int RD = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_mode;
    logic        uart_wen;
    logic [RD:0] uart_addr;
    logic [31:0] uart_data;
    logic        redir_offset;
    logic [31:0] redir_base;
    logic [31:0] redir_offset_value;
    logic        redir_overload;
    logic [31:0] redir_overload_value;
    logic        pc_reset;
    logic        id_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [2:0]  queue_count;
    logic [31:0] fetch_pc;

    if_fetch_queue #(.ISA_WIDTH(32), .ROM_DEPTH(RD), .QUEUE_DEPTH(4),
                     .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .uart_mode(uart_mode), .uart_wen(uart_wen),
        .uart_addr(uart_addr), .uart_data(uart_data),
        .redir_offset(redir_offset), .redir_base(redir_base),
        .redir_offset_value(redir_offset_value),
        .redir_overload(redir_overload),
        .redir_overload_value(redir_overload_value),
        .pc_reset(pc_reset), .id_ready(id_ready),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .queue_count(queue_count), .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    int          total = 0;
    int          bad   = 0;
    ent_t        mq[$];
    logic [31:0] rom_m [64];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_fpc;
    bit          m_load;
    logic [31:0] m_last_inst;
    logic [31:0] m_last_pc;
    int          load_left;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend      = 1'b0;
        m_pend_pc   = '0;
        m_fpc       = '0;
        m_load      = 1'b0;
        m_last_inst = '0;
        m_last_pc   = '0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        bit          pop;
        bit          room;
        if (mq.size() != 0) begin
            m_last_inst = mq[0].ins;
            m_last_pc   = mq[0].pc;
        end
        pop = (mq.size() != 0) && id_ready;
        if (m_load || uart_mode) begin
            if (uart_wen && !uart_addr[RD]) rom_m[uart_addr[RD-1:0]] = uart_data;
            mq.delete();
            m_pend = 1'b0;
            if (m_load && !uart_mode) begin
                m_load = 1'b0;
                m_fpc  = '0;
            end else begin
                m_load = 1'b1;
                if (pc_reset) m_fpc = '0;
            end
        end else if (pc_reset || redir_overload || redir_offset) begin
            if (pc_reset) tgt = 32'h0;
            else if (redir_overload) tgt = redir_overload_value;
            else tgt = redir_base + redir_offset_value * 4;
            mq.delete();
            m_pend = 1'b0;
            m_fpc  = tgt;
        end else begin
            room = (mq.size() + int'(m_pend)) < 4;
            if (pop) void'(mq.pop_front());
            if (m_pend) mq.push_back('{m_pend_pc, rom_m[m_pend_pc[RD+1:2]]});
            m_pend = room;
            if (room) begin
                m_pend_pc = m_fpc;
                m_fpc     = m_fpc + 32'd4;
            end
        end
    endtask

    task automatic compare();
        logic [31:0] ei;
        logic [31:0] ep;
        ei = (mq.size() != 0) ? mq[0].ins : m_last_inst;
        ep = (mq.size() != 0) ? mq[0].pc : m_last_pc;
        chk("vld", 32'(inst_valid), 32'(mq.size() != 0));
        chk("cnt", 32'(queue_count), 32'(mq.size()));
        chk("fpc", fetch_pc, m_fpc);
        chk("inst", inst, ei);
        chk("ipc", inst_pc, ep);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic clear_redir();
        pc_reset       = 1'b0;
        redir_overload = 1'b0;
        redir_offset   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        uart_mode = 1'b1; uart_wen = 1'b0; uart_addr = '0; uart_data = '0;
        redir_offset = 1'b0; redir_base = '0; redir_offset_value = '0;
        redir_overload = 1'b0; redir_overload_value = '0;
        pc_reset = 1'b0; id_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        compare();

        for (int i = 0; i < 64; i++) begin
            uart_wen = 1'b1; uart_addr = 7'(i); uart_data = $urandom();
            cyc();
        end
        uart_wen = 1'b0; uart_mode = 1'b0;
        cyc();

        id_ready = 1'b1;
        cyc(); cyc();
        chk("t1_inst0", inst, rom_m[0]);
        chk("t1_pc0", inst_pc, 32'h0);
        cyc();
        chk("t1_pc4", inst_pc, 32'h4);
        cyc();
        chk("t1_inst2", inst, rom_m[2]);

        pc_reset = 1'b1; id_ready = 1'b0;
        cyc();
        clear_redir();
        repeat (10) cyc();
        chk("t2_cnt", 32'(queue_count), 32'd4);
        chk("t2_fpc", fetch_pc, 32'd16);
        id_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_drain", inst, rom_m[i]);
            chk("t2_dvld", 32'(inst_valid), 32'd1);
            cyc();
        end

        id_ready = 1'b0;
        repeat (6) cyc();
        chk("t3_full", 32'(queue_count), 32'd4);
        redir_offset = 1'b1; redir_base = 32'd8; redir_offset_value = 32'd3;
        cyc();
        clear_redir();
        chk("t3_vld0", 32'(inst_valid), 32'd0);
        chk("t3_cnt0", 32'(queue_count), 32'd0);
        cyc(); cyc();
        chk("t3_pc", inst_pc, 32'd20);
        chk("t3_inst", inst, rom_m[5]);

        id_ready = 1'b1;
        pc_reset = 1'b1; redir_overload = 1'b1; redir_overload_value = 32'h40;
        cyc();
        clear_redir();
        cyc(); cyc();
        chk("t4_prio", inst_pc, 32'h0);
        redir_overload = 1'b1;
        cyc();
        clear_redir();
        cyc(); cyc();
        chk("t4_ovl_pc", inst_pc, 32'h40);
        chk("t4_ovl_inst", inst, rom_m[16]);

        uart_mode = 1'b1;
        cyc();
        uart_wen = 1'b1; uart_addr = 7'd2; uart_data = 32'hDEADBEEF;
        cyc();
        uart_addr = 7'h42; uart_data = 32'h12345678;
        cyc();
        uart_wen = 1'b0; uart_mode = 1'b0;
        cyc();
        chk("t5_fpc", fetch_pc, 32'h0);
        cyc(); cyc(); cyc(); cyc();
        chk("t5_pc", inst_pc, 32'h8);
        chk("t5_inst", inst, 32'hDEADBEEF);

        pc_reset = 1'b1; id_ready = 1'b0;
        cyc();
        clear_redir();
        for (int k = 0; k < 10 && queue_count != 3'd3; k++) cyc();
        chk("t6_cnt3", 32'(queue_count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_vld", 32'(inst_valid), 32'd0);
        chk("t6_cnt", 32'(queue_count), 32'd0);
        chk("t6_fpc", fetch_pc, 32'h0);
        chk("t6_inst", inst, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        compare();
        id_ready = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        chk("t6_rom", inst, 32'hDEADBEEF);

        load_left = 0;
        for (int n = 0; n < 1500; n++) begin
            id_ready = ($urandom_range(0, 9) < 7);
            pc_reset = ($urandom_range(0, 49) == 0);
            redir_overload = ($urandom_range(0, 24) == 0);
            redir_offset = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) redir_overload_value = 32'hFFFFFFF0;
            else if ($urandom_range(0, 3) == 0) redir_overload_value = $urandom();
            else redir_overload_value = 32'($urandom_range(0, 127)) * 4;
            redir_base = $urandom();
            redir_offset_value = 32'($urandom_range(0, 32)) - 32'd16;
            if (load_left > 0) begin
                load_left--;
                uart_mode = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                load_left = $urandom_range(1, 6);
                uart_mode = 1'b1;
            end else begin
                uart_mode = 1'b0;
            end
            uart_wen = $urandom_range(0, 1) == 1 && (uart_mode || !m_load);
            uart_addr = 7'($urandom());
            uart_data = $urandom();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
